instr_encoder: RTL

- Inverse of the instruction field decoder: packs MIPS fields (op/rs/rt/rd/sh/fn, imm, target) into 32-bit R/I/J instruction words.
- Streams the packed words into instruction memory at consecutive word addresses.
- Used as the program loader ahead of the GPP core: a testbench or host feeds fields over a valid/ready handshake, and the block drives the IMEM write port.

---
 rtl/instr_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS R/I/J fields into 32-bit instruction words and
// streams them into instruction memory at consecutive word addresses.
// Acts as the program loader ahead of the core.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        sh,
    input  logic [5:0]        fn,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_fmt,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         word_next;
    logic [ADDR_W:0]     count_next;
    logic                accept;
    logic                fmt_bad;

    // Start always wins over a bundle presented in the same cycle.
    assign in_ready   = (state_reg == LOAD) && (count < DEPTH_C) && !start;
    assign accept     = in_valid && in_ready;
    assign fmt_bad    = (fmt == 2'b11);
    assign count_next = count + 1'b1;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);

    // Field packing; fields not used by the selected format are ignored.
    always_comb begin
        word_next = 32'd0;
        case (fmt)
            FMT_R:   word_next = {op, rs, rt, rd, sh, fn};
            FMT_I:   word_next = {op, rs, rt, imm};
            FMT_J:   word_next = {op, target};
            default: word_next = 32'd0;
        endcase
    end

    // Session FSM, address/count tracking and the registered IMEM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= BASE_C;
            count     <= '0;
            err_fmt   <= 1'b0;
            ovf       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                // Begin or abort-and-restart; a write registered last cycle
                // is already on the port and simply completes.
                state_reg <= LOAD;
                addr_reg  <= BASE_C;
                count     <= '0;
                err_fmt   <= 1'b0;
                ovf       <= 1'b0;
            end else begin
                case (state_reg)
                    LOAD: begin
                        if (accept) begin
                            if (fmt_bad) begin
                                // Illegal bundle is consumed without a write.
                                err_fmt <= 1'b1;
                                if (last) begin
                                    state_reg <= FIN;
                                end
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr_reg;
                                mem_wdata <= word_next;
                                addr_reg  <= addr_reg + 1'b1;
                                count     <= count_next;
                                if (last) begin
                                    state_reg <= FIN;
                                end else if (count_next == DEPTH_C) begin
                                    ovf       <= 1'b1;
                                    state_reg <= FIN;
                                end
                            end
                        end
                    end
                    FIN:     state_reg <= IDLE;
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

endmodule
